// File: rtl/pe_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pe_cfg_ctrl
// Purpose  : Configuration and run sequencer for NUM_PE PE functional units.
//            Clears the FUs, streams one config word per PE from a
//            valid/ready channel onto a broadcast bus with one-hot write
//            strobes, raises pe_cfgd, then collects per-PE done pulses until
//            every PE has finished.
// Ports    : clk, rst_n (async, active-low)
//            start, abort                 - sequence control
//            cfg_in_valid/cfg_in/cfg_in_par, cfg_in_ready - config channel
//            cfg_out, cfg_we              - registered broadcast data/strobes
//            pe_cfgd, pe_clear, pe_fu_done - PE FU pins
//            busy, done, cfg_err          - status
// Options  : PE_CFG_PARITY_EN - even-parity check of each loaded word, with
//            an ERR state entered on mismatch. Undefined: cfg_err tied 0.
// Revision : 1.0 - initial release
// ============================================================================
module pe_cfg_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PE     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  cfg_in_valid,
  input  logic [DATA_WIDTH-1:0] cfg_in,
  input  logic                  cfg_in_par,
  output logic                  cfg_in_ready,
  output logic [DATA_WIDTH-1:0] cfg_out,
  output logic [NUM_PE-1:0]     cfg_we,
  output logic                  pe_cfgd,
  output logic                  pe_clear,
  input  logic [NUM_PE-1:0]     pe_fu_done,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  localparam int              IDX_W      = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_PE - 1);
  localparam logic [NUM_PE-1:0] C_ONE     = NUM_PE'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
`ifdef PE_CFG_PARITY_EN
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
`else
    S_DONE  = 3'd4
`endif
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [IDX_W-1:0]     r_idx;
  logic [NUM_PE-1:0]    r_mask;
  logic                 w_hs;
  logic                 w_par_ok;
  logic                 w_write;
  logic                 w_clear_pulse;
  logic                 w_all_done;

  assign cfg_in_ready = (r_state == S_LOAD) && !abort;
  assign w_hs         = cfg_in_ready && cfg_in_valid;
  assign w_write      = w_hs && w_par_ok;
  // Completion only counts once pe_cfgd is visible to the PEs; a pulse in the
  // same cycle as the final missing bit finishes the run immediately.
  assign w_all_done   = pe_cfgd && (&(r_mask | pe_fu_done));

`ifdef PE_CFG_PARITY_EN
  assign w_par_ok = ~(^{cfg_in, cfg_in_par});
`else
  logic w_unused_par;
  assign w_unused_par = cfg_in_par;
  assign w_par_ok     = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; abort outranks start and any same-cycle handshake.
  always_comb begin
    w_next_state  = r_state;
    w_clear_pulse = 1'b0;
    if (abort && (r_state != S_IDLE)) begin
      w_next_state  = S_IDLE;
      w_clear_pulse = 1'b1;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            w_next_state  = S_CLEAR;
            w_clear_pulse = 1'b1;
          end
        end
`ifdef PE_CFG_PARITY_EN
        S_ERR: begin
          if (start) begin
            w_next_state  = S_CLEAR;
            w_clear_pulse = 1'b1;
          end
        end
`endif
        S_CLEAR: w_next_state = S_LOAD;
        S_LOAD: begin
          if (w_hs) begin
            if (!w_par_ok) begin
`ifdef PE_CFG_PARITY_EN
              w_next_state  = S_ERR;
              w_clear_pulse = 1'b1;
`endif
            end else if (r_idx == C_LAST_IDX) begin
              w_next_state = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_all_done) begin
            w_next_state = S_DONE;
          end
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Datapath and registered status decodes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_mask   <= '0;
      cfg_out  <= '0;
      cfg_we   <= '0;
      pe_cfgd  <= 1'b0;
      pe_clear <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      cfg_we   <= '0;
      pe_clear <= w_clear_pulse;
      // pe_cfgd follows RUN one cycle late but drops together with the exit.
      pe_cfgd  <= (r_state == S_RUN) && (w_next_state == S_RUN);
      busy     <= (w_next_state == S_CLEAR) || (w_next_state == S_LOAD) ||
                  (w_next_state == S_RUN);
      done     <= (w_next_state == S_DONE);
      if (w_next_state == S_CLEAR) begin
        r_idx  <= '0;
        r_mask <= '0;
      end
      if (w_write) begin
        cfg_out <= cfg_in;
        cfg_we  <= C_ONE << r_idx;
        r_idx   <= r_idx + IDX_W'(1);
      end
      if ((r_state == S_RUN) && pe_cfgd) begin
        r_mask <= r_mask | pe_fu_done;
      end
    end
  end

`ifdef PE_CFG_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= (w_next_state == S_ERR);
    end
  end
`else
  assign cfg_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pe_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_cfg_ctrl
// Purpose  : Self-checking bench for pe_cfg_ctrl (NUM_PE=4, DATA_WIDTH=32).
//            Expected strobes, data, and completion are derived from a
//            word-count / done-mask reference model kept in the bench.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_cfg_ctrl;
  localparam int DW = 32;
  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          cfg_in_valid = 1'b0;
  logic [DW-1:0] cfg_in = '0;
  logic          cfg_in_par = 1'b0;
  logic [NP-1:0] pe_fu_done = '0;
  logic          cfg_in_ready;
  logic [DW-1:0] cfg_out;
  logic [NP-1:0] cfg_we;
  logic          pe_cfgd, pe_clear, busy, done, cfg_err;

  int            n_tests = 0;
  int            n_fail = 0;
  logic [DW-1:0] m_out = '0;   // model of the last word written to the PEs

  pe_cfg_ctrl #(.DATA_WIDTH(DW), .NUM_PE(NP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_in_valid(cfg_in_valid), .cfg_in(cfg_in), .cfg_in_par(cfg_in_par),
    .cfg_in_ready(cfg_in_ready), .cfg_out(cfg_out), .cfg_we(cfg_we),
    .pe_cfgd(pe_cfgd), .pe_clear(pe_clear), .pe_fu_done(pe_fu_done),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    n_tests++;
    if ({cfg_out, cfg_we, pe_cfgd, pe_clear, busy, done, cfg_err, cfg_in_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got out=%h we=%b cfgd=%b clr=%b busy=%b done=%b err=%b rdy=%b, want all 0",
               cfg_out, cfg_we, pe_cfgd, pe_clear, busy, done, cfg_err, cfg_in_ready);
    end
    rst_n = 1'b1;
    step();
    abort = 1'b1;       // abort while idle must not pulse clear
    step();
    abort = 1'b0;
    n_tests++;
    if ({pe_clear, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_abort: got clr/busy/done=%b want 000", {pe_clear, busy, done});
    end
  endtask

  // start from IDLE/DONE/ERR, then check the CLEAR cycle and LOAD entry
  task automatic start_seq();
    start = 1'b1;
    step();
    start = 1'b0;
    n_tests++;
    if ({pe_clear, busy, done, pe_cfgd, cfg_err, cfg_we, cfg_in_ready} !== {5'b11000, 4'b0000, 1'b0}) begin
      n_fail++;
      $display("FAIL clear_cycle: got clr=%b busy=%b done=%b cfgd=%b err=%b we=%b rdy=%b",
               pe_clear, busy, done, pe_cfgd, cfg_err, cfg_we, cfg_in_ready);
    end
    step();
    n_tests++;
    if ({pe_clear, busy, cfg_in_ready} !== 3'b011) begin
      n_fail++;
      $display("FAIL load_entry: got clr/busy/rdy=%b want 011", {pe_clear, busy, cfg_in_ready});
    end
  endtask

  // Load words k0..n_stop-1. mode 0: back-to-back fixed 0x11*(k+1);
  // mode 1: valid pattern 1,0,0; mode 2: random valid. Start is randomly
  // asserted in modes 1/2 and must be ignored.
  task automatic run_load(input int k0, input int n_stop, input int mode);
    int k = k0;
    int c = 0;
    while (k < n_stop && c < 200) begin
      logic          v;
      logic [DW-1:0] w;
      logic [NP-1:0] exp_we;
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 3 == 0) : 1'($urandom_range(0, 1));
      w = (mode == 0) ? DW'(32'h11 * (k + 1)) : DW'($urandom);
      cfg_in_valid = v; cfg_in = w; cfg_in_par = ^w;
      start = (mode != 0) && ($urandom_range(0, 3) == 0);
      pe_fu_done = NP'($urandom);
      #1;
      n_tests++;
      if (cfg_in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL load_ready: got %b want 1 (word %0d)", cfg_in_ready, k);
      end
      step();
      if (v) begin
        exp_we = NP'(1) << k;
        m_out  = w;
        k++;
      end else begin
        exp_we = '0;
      end
      n_tests++;
      if ({cfg_we, cfg_out, busy, pe_cfgd, done} !== {exp_we, m_out, 3'b100}) begin
        n_fail++;
        $display("FAIL load_word: got we=%b out=%h busy=%b cfgd=%b done=%b want we=%b out=%h busy=1 cfgd=0 done=0",
                 cfg_we, cfg_out, busy, pe_cfgd, done, exp_we, m_out);
      end
      c++;
    end
    n_tests++;
    if (k < n_stop) begin
      n_fail++;
      $display("FAIL load_timeout: loaded %0d want %0d", k, n_stop);
    end
    cfg_in_valid = 1'b0; start = 1'b0; pe_fu_done = '0;
  endtask

  // First RUN cycle: pe_cfgd still low, done pulses ignored, ready low.
  task automatic enter_run(input bit keep_valid);
    cfg_in_valid = keep_valid; cfg_in = DW'($urandom); pe_fu_done = '1;
    #1;
    n_tests++;
    if (cfg_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL run_ready: got %b want 0", cfg_in_ready);
    end
    step();
    n_tests++;
    if ({pe_cfgd, cfg_we, busy, done, cfg_out} !== {1'b1, 4'b0000, 2'b10, m_out}) begin
      n_fail++;
      $display("FAIL run_entry: got cfgd=%b we=%b busy=%b done=%b out=%h want cfgd=1 we=0 busy=1 done=0 out=%h",
               pe_cfgd, cfg_we, busy, done, cfg_out, m_out);
    end
    pe_fu_done = '0; cfg_in_valid = 1'b0;
  endtask

  // mode 0: PE2,PE0,PE2,PE3,PE1 with idle cycles between; mode 1: random
  task automatic run_to_done(input int mode);
    logic [NP-1:0] seq [9] = '{4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b0100,
                               4'b0000, 4'b1000, 4'b0000, 4'b0010};
    logic [NP-1:0] m_mask = '0;
    bit fin = 1'b0;
    int c = 0;
    while (!fin && c < 200) begin
      logic [NP-1:0] vec;
      if (mode == 0) vec = (c < 9) ? seq[c] : '0;
      else           vec = ($urandom_range(0, 2) == 0) ? NP'($urandom) : '0;
      pe_fu_done = vec;
      start = 1'($urandom_range(0, 1));
      step();
      m_mask = m_mask | vec;
      fin = (m_mask == '1);
      n_tests++;
      if ({done, pe_cfgd, busy} !== (fin ? 3'b100 : 3'b011)) begin
        n_fail++;
        $display("FAIL run_track: got done/cfgd/busy=%b want %b (mask %b)",
                 {done, pe_cfgd, busy}, (fin ? 3'b100 : 3'b011), m_mask);
      end
      c++;
    end
    pe_fu_done = '0; start = 1'b0;
    n_tests++;
    if (!fin) begin
      n_fail++;
      $display("FAIL run_timeout: mask %b never complete", m_mask);
    end
    step(); step();
    n_tests++;
    if ({done, busy, pe_cfgd, pe_clear} !== 4'b1000) begin
      n_fail++;
      $display("FAIL done_hold: got done/busy/cfgd/clr=%b want 1000", {done, busy, pe_cfgd, pe_clear});
    end
  endtask

  task automatic test_basic_load();
    start_seq();
    run_load(0, NP, 0);
    enter_run(1'b0);
    run_to_done(0);
  endtask

  task automatic test_bubbles();
    start_seq();                 // starts from DONE: done must drop
    run_load(0, NP, 1);
    enter_run(1'b1);
    run_to_done(1);
  endtask

  task automatic test_abort();
    start_seq();
    run_load(0, 2, 2);
    abort = 1'b1; start = 1'b1; cfg_in_valid = 1'b1; cfg_in = DW'($urandom);
    #1;
    n_tests++;
    if (cfg_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_ready: got %b want 0", cfg_in_ready);
    end
    step();
    abort = 1'b0; start = 1'b0; cfg_in_valid = 1'b0;
    n_tests++;
    if ({pe_clear, busy, pe_cfgd, done, cfg_we, cfg_out} !== {4'b1000, 4'b0000, m_out}) begin
      n_fail++;
      $display("FAIL abort_load: got clr=%b busy=%b cfgd=%b done=%b we=%b out=%h want 1,0,0,0,0000,%h",
               pe_clear, busy, pe_cfgd, done, cfg_we, cfg_out, m_out);
    end
    step();
    n_tests++;
    if ({pe_clear, busy, cfg_in_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_idle: got clr/busy/rdy=%b want 000", {pe_clear, busy, cfg_in_ready});
    end
    start_seq();
    run_load(0, NP, 2);
    enter_run(1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_tests++;
    if ({pe_clear, pe_cfgd, busy, done} !== 4'b1000) begin
      n_fail++;
      $display("FAIL abort_run: got clr/cfgd/busy/done=%b want 1000", {pe_clear, pe_cfgd, busy, done});
    end
    step();
  endtask

  task automatic test_parity();
    logic [DW-1:0] w0;
    start_seq();
    w0 = DW'($urandom);
    cfg_in_valid = 1'b1; cfg_in = w0; cfg_in_par = ^w0;
    step();
    m_out = w0;
    n_tests++;
    if ({cfg_we, cfg_out} !== {4'b0001, w0}) begin
      n_fail++;
      $display("FAIL par_word0: got we=%b out=%h want 0001 %h", cfg_we, cfg_out, w0);
    end
    cfg_in = 32'h0000_0001; cfg_in_par = 1'b0;
    step();
    cfg_in_valid = 1'b0;
`ifdef PE_CFG_PARITY_EN
    n_tests++;
    if ({cfg_we, cfg_err, pe_clear, busy, pe_cfgd} !== {4'b0000, 4'b1100}) begin
      n_fail++;
      $display("FAIL par_err_entry: got we=%b err=%b clr=%b busy=%b cfgd=%b want 0000 1 1 0 0",
               cfg_we, cfg_err, pe_clear, busy, pe_cfgd);
    end
    step(); step();
    n_tests++;
    if ({cfg_err, pe_clear, busy, cfg_in_ready} !== 4'b1000) begin
      n_fail++;
      $display("FAIL par_err_hold: got err/clr/busy/rdy=%b want 1000", {cfg_err, pe_clear, busy, cfg_in_ready});
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n_tests++;
    if ({cfg_err, pe_clear, busy} !== 3'b011) begin
      n_fail++;
      $display("FAIL par_restart: got err/clr/busy=%b want 011", {cfg_err, pe_clear, busy});
    end
    step();
    run_load(0, NP, 2);
`else
    m_out = 32'h0000_0001;
    n_tests++;
    if ({cfg_we, cfg_out, cfg_err} !== {4'b0010, 32'h0000_0001, 1'b0}) begin
      n_fail++;
      $display("FAIL par_ignored: got we=%b out=%h err=%b want 0010 00000001 0", cfg_we, cfg_out, cfg_err);
    end
    run_load(2, NP, 2);
`endif
    enter_run(1'b0);
    run_to_done(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      start_seq();
      run_load(0, NP, 2);
      enter_run(1'($urandom_range(0, 1)));
      run_to_done(1);
    end
  endtask

  task automatic test_reset_midop();
    start_seq();
    run_load(0, 2, 2);
    #2 rst_n = 1'b0;
    #1;
    m_out = '0;
    n_tests++;
    if ({cfg_out, cfg_we, pe_cfgd, pe_clear, busy, done, cfg_err, cfg_in_ready} !== '0) begin
      n_fail++;
      $display("FAIL midop_reset: got out=%h we=%b cfgd=%b clr=%b busy=%b done=%b err=%b rdy=%b, want all 0",
               cfg_out, cfg_we, pe_cfgd, pe_clear, busy, done, cfg_err, cfg_in_ready);
    end
    #10 rst_n = 1'b1;
    step();
    n_tests++;
    if ({pe_clear, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL midop_release: got clr/busy=%b want 00", {pe_clear, busy});
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_bubbles();
    test_abort();
    test_parity();
    test_random();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/pe_cfg_ctrl.md
Name: pe_cfg_ctrl

Overview:
Configuration and run sequencer for a group of NUM_PE PE functional units.
- Clears the FUs, then streams one configuration word per PE from a valid/ready config channel onto a broadcast bus with one-hot write strobes.
- Raises the shared cfgd level and tracks each FU's done pulse until every PE has finished.
- Sits between the fabric config loader and the PE FU cfg/cfgd/clear/fu_done pins.

Parameters:
DATA_WIDTH, 32, width of one configuration word
NUM_PE, 4, number of PEs sequenced (>=1); index counter width is $clog2(NUM_PE) (min 1)

Ports:
clk  in  1  clock
rst_n  in  1  reset
start  in  1  begin clear+load sequence; honoured only in IDLE, DONE, ERR
abort  in  1  cancel any sequence, return to IDLE
cfg_in_valid  in  1  config word valid
cfg_in  in  DATA_WIDTH  config word
cfg_in_par  in  1  even-parity bit for cfg_in (used only with macro)
cfg_in_ready  out  1  controller accepts config word
cfg_out  out  DATA_WIDTH  registered broadcast config data to all PEs
cfg_we  out  NUM_PE  registered one-hot write strobe, bit i = PE i
pe_cfgd  out  1  configuration-done level to all PE FUs
pe_clear  out  1  one-cycle clear pulse to all PE FUs
pe_fu_done  in  NUM_PE  per-PE FU done pulses
busy  out  1  state is CLEAR, LOAD or RUN
done  out  1  all PEs reported done; held in DONE
cfg_err  out  1  parity error flag (tied 0 without macro)

Behaviour:
- One clock, clk; reset rst_n is asynchronous, active-low.
- Reset: state=IDLE, idx=0, done mask=0. cfg_out=0, cfg_we=0, pe_cfgd=0, pe_clear=0, done=0, busy=0, cfg_err=0.
- States: IDLE, CLEAR, LOAD, RUN, DONE, plus ERR with macro only.
- IDLE/DONE/ERR + start: go to CLEAR; idx=0, done mask=0, done and cfg_err drop next cycle.
- CLEAR: pe_clear=1 for exactly this one cycle, pe_cfgd=0. Unconditionally go to LOAD next cycle.
- LOAD:
  - cfg_in_ready = (state==LOAD) && !abort (combinational).
  - Handshake at cycle T: cfg_out=cfg_in and cfg_we=onehot(idx) in cycle T+1. cfg_we is a single-cycle pulse, else 0. idx increments.
  - cfg_out holds its value between handshakes.
  - Bubbles (valid low) stall with no strobe.
  - Handshake with idx==NUM_PE-1: state=RUN at T+1, pe_cfgd=1 from T+2 (pe_cfgd is a register of state==RUN).
- RUN:
  - Sticky mask |= pe_fu_done, sampled only while pe_cfgd=1.
  - Repeated pulses from one PE are harmless.
  - When (mask | pe_fu_done) is all-ones in cycle T: DONE at T+1, done=1 and pe_cfgd=0 at T+1.
  - pe_fu_done is ignored in all other states.
- DONE: done=1 held until start or abort.
- start in CLEAR/LOAD/RUN: ignored.
- abort, any state except IDLE:
  - Next cycle: IDLE, pe_clear=1 for one cycle, pe_cfgd=0, cfg_we=0, done=0, cfg_err=0.
  - Priority over start and over a same-cycle handshake; that word is not accepted.
- abort in IDLE: no effect, no clear pulse.
- busy and done are registered decodes of state.
- Reset asserted mid-operation: immediate return to reset values, no clear pulse.

Optional Feature:
PE_CFG_PARITY_EN
- Defined:
  - Each LOAD handshake checks ^{cfg_in,cfg_in_par}==0.
  - On mismatch the word is consumed but not written (no cfg_we), idx does not advance, and state goes to ERR.
  - ERR: cfg_err=1 from next cycle; pe_clear pulses one cycle on ERR entry; pe_cfgd=0.
  - ERR exits only via start (to CLEAR, cfg_err cleared) or abort (to IDLE).
- Undefined: cfg_in_par is ignored, cfg_err is constant 0, there is no ERR state.

Test Plan:
1. NUM_PE=4; reset, start, back-to-back words 0x11,0x22,0x33,0x44 -> cfg_we 0001,0010,0100,1000 on four consecutive cycles with matching cfg_out; pe_clear one pulse before loading; pe_cfgd=1 two cycles after the last handshake; busy=1 throughout.
2. Same load with cfg_in_valid toggling 1,0,0,1,... -> strobes only after accepted words, cfg_out held in gaps; cfg_in_ready=0 in RUN while valid stays high.
3. RUN, pe_fu_done pulses PE2, PE0, PE2, PE3, PE1 on separate cycles -> done=1 and pe_cfgd=0 exactly one cycle after the PE1 pulse, not before.
4. abort after 2 of 4 words, with valid high that cycle -> word not taken, one pe_clear pulse, IDLE, busy=0, pe_cfgd=0; next start reloads from cfg_we=0001.
5. start while in DONE -> done drops next cycle, pe_clear pulse, full reload; start asserted during LOAD is ignored (idx unaffected).
6. Macro on: word index 1 = 0x00000001 with par=0 -> no cfg_we[1], cfg_err=1, pe_clear pulse, ERR held; then start clears cfg_err. Macro off: same stimulus writes 0x1 with cfg_we=0010.
